// File: rtl/pio_pkg.sv
// Shared constants for the PIO input-port block.
//   ADDR_*  : Avalon-MM register offsets (2-bit word address)
//   EDGE_*  : capture-mode selector values for the EDGE_TYPE parameter
package pio_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_RSVD    = 2'd1;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/pio_in_edge_capture_if.sv
// Avalon-MM slave bus bundle for the PIO input port.
//   address[1:0]    register select
//   chipselect      slave select
//   read_n/write_n  active-low strobes
//   writedata[31:0] write data (master -> slave)
//   readdata[31:0]  registered read data (slave -> master)
interface pio_in_edge_capture_if;

  logic [1:0]  address;
  logic        chipselect;
  logic        read_n;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, read_n, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, read_n, write_n, writedata,
    output readdata
  );

endinterface

// File: rtl/pio_sync_edge.sv
// Input synchroniser plus edge detector for the PIO input port.
//   clk, reset_n : system clock, asynchronous active-low reset
//   in_port      : asynchronous external inputs
//   sync_q       : synchronised copy of in_port (SYNC_STAGES flops deep)
//   sel          : one-cycle pulse per bit for each edge of the selected type,
//                  held at zero until the warm-up counter completes
module pio_sync_edge
  import pio_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int EDGE_TYPE   = EDGE_RISE,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] sync_q,
  output logic [WIDTH-1:0] sel
);

  // The synchroniser clears to 0 on reset, so an input already high would
  // look like a rising edge once it propagates. Masking sel for one cycle
  // beyond the chain depth lets prev catch up before anything is captured.
  localparam int WARM_CYCLES = SYNC_STAGES + 1;

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_reg;
  logic [WIDTH-1:0]                  prev_reg;
  logic [2:0]                        warm_cnt_reg;
  logic                              warm_done;
  logic [WIDTH-1:0]                  rise;
  logic [WIDTH-1:0]                  fall;
  logic [WIDTH-1:0]                  edge_raw;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_reg <= '0;
      prev_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], in_port};
      prev_reg <= sync_reg[SYNC_STAGES-1];
    end
  end

  // Saturating counter: stops at WARM_CYCLES and stays there until reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      warm_cnt_reg <= '0;
    end else if (!warm_done) begin
      warm_cnt_reg <= warm_cnt_reg + 3'd1;
    end
  end

  assign warm_done = (warm_cnt_reg == 3'(WARM_CYCLES));
  assign sync_q    = sync_reg[SYNC_STAGES-1];
  assign rise      = sync_q & ~prev_reg;
  assign fall      = ~sync_q & prev_reg;

  generate
    if (EDGE_TYPE == EDGE_RISE) begin : g_rise
      assign edge_raw = rise;
    end else if (EDGE_TYPE == EDGE_FALL) begin : g_fall
      assign edge_raw = fall;
    end else begin : g_any
      assign edge_raw = rise | fall;
    end
  endgenerate

  assign sel = warm_done ? edge_raw : '0;

endmodule

// File: rtl/pio_in_edge_capture.sv
// Avalon-MM slave input PIO with sticky edge capture and level interrupt.
//   clk, reset_n : system clock, asynchronous active-low reset
//   bus          : Avalon-MM slave (address/chipselect/read_n/write_n/
//                  writedata in, registered readdata out, read latency 1)
//   in_port      : asynchronous external inputs
//   irq          : active-high level interrupt, |(edgecapture & irqmask)
// Registers: 0 DATA (RO), 1 reserved (reads 0), 2 IRQMASK (RW),
//            3 EDGECAPTURE (read, write-1-to-clear).
module pio_in_edge_capture
  import pio_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int EDGE_TYPE   = EDGE_RISE,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    reset_n,
  pio_in_edge_capture_if.slave    bus,
  input  logic [WIDTH-1:0]        in_port,
  output logic                    irq
);

  logic [WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] sel;
  logic [WIDTH-1:0] edgecap_reg;
  logic [WIDTH-1:0] irqmask_reg;
  logic [31:0]      readdata_reg;
  logic [WIDTH-1:0] clr;
  logic [31:0]      read_mux;
  logic             rd_en;
  logic             wr_en;

  pio_sync_edge #(
    .WIDTH       (WIDTH),
    .EDGE_TYPE   (EDGE_TYPE),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_edge (
    .clk     (clk),
    .reset_n (reset_n),
    .in_port (in_port),
    .sync_q  (sync_q),
    .sel     (sel)
  );

  assign rd_en = bus.chipselect & ~bus.read_n;
  assign wr_en = bus.chipselect & ~bus.write_n;
  assign clr   = (wr_en && bus.address == ADDR_EDGECAP) ? bus.writedata[WIDTH-1:0] : '0;

  // Mux is built from current register values, so a read issued together
  // with a write or a capture returns the pre-update contents.
  always_comb begin
    read_mux = '0;
    case (bus.address)
      ADDR_DATA:    read_mux = 32'(sync_q);
      ADDR_IRQMASK: read_mux = 32'(irqmask_reg);
      ADDR_EDGECAP: read_mux = 32'(edgecap_reg);
      default:      read_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edgecap_reg  <= '0;
      irqmask_reg  <= '0;
      readdata_reg <= '0;
    end else begin
      // OR-ing sel after the clear makes a fresh edge win over a same-cycle W1C.
      edgecap_reg <= (edgecap_reg & ~clr) | sel;
      if (wr_en && bus.address == ADDR_IRQMASK) begin
        irqmask_reg <= bus.writedata[WIDTH-1:0];
      end
      if (rd_en) begin
        readdata_reg <= read_mux;
      end
    end
  end

  assign bus.readdata = readdata_reg;
  assign irq          = |(edgecap_reg & irqmask_reg);

endmodule

// File: tb/tb_pio_in_edge_capture.sv
// Scoreboard bench: two instances (rising-edge and any-edge capture) share
// in_port and bus stimulus. A history-based reference model predicts each
// read result and irq; a monitor pops and compares when read data is valid.
module tb_pio_in_edge_capture;
  import pio_pkg::*;

  localparam int S = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] in_port;
  logic        cs, rdn, wrn;
  logic [1:0]  addr;
  logic [31:0] wdata;
  logic        irq_r, irq_a;

  always #5 clk = ~clk;

  pio_in_edge_capture_if bus_r ();
  pio_in_edge_capture_if bus_a ();

  assign bus_r.chipselect = cs;
  assign bus_r.read_n     = rdn;
  assign bus_r.write_n    = wrn;
  assign bus_r.address    = addr;
  assign bus_r.writedata  = wdata;
  assign bus_a.chipselect = cs;
  assign bus_a.read_n     = rdn;
  assign bus_a.write_n    = wrn;
  assign bus_a.address    = addr;
  assign bus_a.writedata  = wdata;

  pio_in_edge_capture #(.WIDTH(32), .EDGE_TYPE(EDGE_RISE), .SYNC_STAGES(S)) dut_rise (
    .clk(clk), .reset_n(reset_n), .bus(bus_r), .in_port(in_port), .irq(irq_r)
  );

  pio_in_edge_capture #(.WIDTH(32), .EDGE_TYPE(EDGE_ANY), .SYNC_STAGES(S)) dut_any (
    .clk(clk), .reset_n(reset_n), .bus(bus_a), .in_port(in_port), .irq(irq_a)
  );

  // ---------------- reference model ----------------
  // hist[j] is the in_port value present at clock edge j+1 after reset release.
  // The synchronised value after n edges is the input sampled S-1 edges earlier;
  // an edge between consecutive synchronised values counts only once more than
  // S edges have elapsed since release (warm-up).
  logic [31:0] hist[$];
  int          k;
  logic [31:0] ec_r, ec_a, mask_m;

  typedef struct {
    string       name;
    logic [31:0] er;
    logic [31:0] ea;
    logic        ir;
    logic        ia;
  } exp_t;
  exp_t sb[$];

  int n_pass  = 0;
  int n_total = 0;

  function automatic logic [31:0] sync_at(int n);
    if (n - S >= 0 && n - S < hist.size()) return hist[n-S];
    return 32'h0;
  endfunction

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", nm, act, exp);
  endtask

  task automatic tick(string nm);
    logic [31:0] s_in, cur, old, clr, rise, fall, mr, ma, wd;
    logic        rd, wr;
    logic [1:0]  a;
    exp_t        e;
    s_in = in_port; rd = cs && !rdn; wr = cs && !wrn; a = addr; wd = wdata;
    @(posedge clk);
    cur = sync_at(k);
    old = sync_at(k - 1);
    case (a)
      ADDR_DATA:    begin mr = cur;    ma = cur;    end
      ADDR_IRQMASK: begin mr = mask_m; ma = mask_m; end
      ADDR_EDGECAP: begin mr = ec_r;   ma = ec_a;   end
      default:      begin mr = 32'h0;  ma = 32'h0;  end
    endcase
    clr  = (wr && a == ADDR_EDGECAP) ? wd : 32'h0;
    rise = 32'h0;
    fall = 32'h0;
    if (k >= S + 1) begin
      rise = cur & ~old;
      fall = ~cur & old;
    end
    ec_r = (ec_r & ~clr) | rise;
    ec_a = (ec_a & ~clr) | rise | fall;
    if (wr && a == ADDR_IRQMASK) mask_m = wd;
    hist.push_back(s_in);
    k++;
    if (rd) begin
      e.name = nm; e.er = mr; e.ea = ma;
      e.ir = |(ec_r & mask_m); e.ia = |(ec_a & mask_m);
      sb.push_back(e);
    end
    #1;
  endtask

  task automatic bus_op(bit r, bit w, logic [1:0] a, logic [31:0] d, string nm);
    cs = 1'b1; rdn = !r; wrn = !w; addr = a; wdata = d;
    tick(nm);
    cs = 1'b0; rdn = 1'b1; wrn = 1'b1;
  endtask

  task automatic rd(logic [1:0] a, string nm);
    bus_op(1'b1, 1'b0, a, 32'h0, nm);
  endtask

  task automatic wr(logic [1:0] a, logic [31:0] d);
    bus_op(1'b0, 1'b1, a, d, "wr");
  endtask

  task automatic idle(int n);
    repeat (n) tick("idle");
  endtask

  task automatic do_reset(string nm);
    #2;
    reset_n = 1'b0;
    #1;
    check({nm, "/irq_rise"}, 32'(irq_r), 32'h0);
    check({nm, "/irq_any"},  32'(irq_a), 32'h0);
    check({nm, "/rdata_rise"}, bus_r.readdata, 32'h0);
    check({nm, "/rdata_any"},  bus_a.readdata, 32'h0);
    hist.delete();
    k = 0; ec_r = 0; ec_a = 0; mask_m = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // ---------------- monitor ----------------
  always @(posedge clk) begin
    if (reset_n && cs && !rdn) begin
      exp_t e;
      #2;
      if (sb.size() == 0) begin
        n_total++;
        $display("FAIL sb_underflow: read data valid with no expectation queued");
      end else begin
        e = sb.pop_front();
        check({e.name, "/rd_rise"},  bus_r.readdata, e.er);
        check({e.name, "/rd_any"},   bus_a.readdata, e.ea);
        check({e.name, "/irq_rise"}, 32'(irq_r), 32'(e.ir));
        check({e.name, "/irq_any"},  32'(irq_a), 32'(e.ia));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    reset_n = 1'b1; cs = 1'b0; rdn = 1'b1; wrn = 1'b1; addr = 2'd0; wdata = 32'h0;
    in_port = 32'hFFFF_FFFF;
    k = 0; ec_r = 0; ec_a = 0; mask_m = 0;
    do_reset("reset");

    // Inputs high through reset: no false edges after warm-up.
    idle(S + 1);
    rd(ADDR_DATA,    "data_after_reset");
    rd(ADDR_EDGECAP, "ec_after_reset");
    rd(ADDR_RSVD,    "rsvd");
    wr(ADDR_DATA, 32'h1234_5678);
    rd(ADDR_DATA,    "data_wr_ignored");

    // Single rising edge on bit 5, read every cycle to pin the latency.
    wr(ADDR_IRQMASK, 32'h20);
    rd(ADDR_IRQMASK, "mask_rb");
    in_port = 32'h0;
    idle(4);
    wr(ADDR_EDGECAP, 32'hFFFF_FFFF);
    rd(ADDR_EDGECAP, "ec_cleared");
    in_port = 32'h20;
    for (int i = 0; i < S + 2; i++) rd(ADDR_EDGECAP, $sformatf("latency_%0d", i));

    // W1C clear, then a zero write that must not disturb captures.
    wr(ADDR_EDGECAP, 32'h20);
    rd(ADDR_EDGECAP, "w1c");
    in_port = 32'h0;
    idle(4);
    wr(ADDR_EDGECAP, 32'h0);
    rd(ADDR_EDGECAP, "w1c_zero");
    wr(ADDR_EDGECAP, 32'hFFFF_FFFF);

    // New edge lands on the same edge as a W1C of that bit: edge wins.
    in_port = 32'h20;
    idle(S);
    wr(ADDR_EDGECAP, 32'h20);
    rd(ADDR_EDGECAP, "edge_vs_clear");

    // Any-edge behaviour on bit 0 with interrupts masked off.
    wr(ADDR_IRQMASK, 32'h0);
    wr(ADDR_EDGECAP, 32'hFFFF_FFFF);
    in_port = 32'h21;
    idle(4);
    rd(ADDR_EDGECAP, "any_rise");
    wr(ADDR_EDGECAP, 32'h1);
    in_port = 32'h20;
    idle(4);
    rd(ADDR_EDGECAP, "any_fall");

    // Randomised traffic, including simultaneous read+write.
    for (int i = 0; i < 300; i++) begin
      int op;
      if ($urandom_range(0, 3) == 0) in_port = in_port ^ ($urandom() & $urandom());
      op = $urandom_range(0, 3);
      case (op)
        0: idle(1);
        1: rd(2'($urandom_range(0, 3)), $sformatf("rand_rd_%0d", i));
        2: wr(2'($urandom_range(0, 3)), $urandom());
        default: bus_op(1'b1, 1'b1, 2'($urandom_range(0, 3)), $urandom(),
                        $sformatf("rand_rw_%0d", i));
      endcase
    end

    // Reset in the middle of an active capture.
    wr(ADDR_IRQMASK, 32'hFF);
    in_port = 32'h0;
    idle(4);
    wr(ADDR_EDGECAP, 32'hFFFF_FFFF);
    in_port = 32'h21;
    idle(4);
    rd(ADDR_EDGECAP, "pre_reset");
    in_port = 32'h0;
    do_reset("mid_reset");
    idle(S + 1);
    for (int a = 0; a < 4; a++) rd(2'(a), $sformatf("post_reset_a%0d", a));

    idle(3);
    check("sb_drain", 32'(sb.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pio_in_edge_capture.md
Name: pio_in_edge_capture

Overview:
- Avalon-MM slave input port: the reader counterpart to the team's 32-bit output PIO.
- Samples an asynchronous external bus (in_port) through a synchroniser and exposes the synchronised value to the CPU.
- Latches selected edges per bit into a sticky capture register and raises a maskable level interrupt.
- Sits on the same system interconnect as the output PIO; the CPU reads status and clears edges by write-1-to-clear.

Parameters:
- WIDTH, 32, port width in bits (1..32); unused readdata bits read 0.
- EDGE_TYPE, 0, capture mode: 0 rising, 1 falling, 2 any edge.
- SYNC_STAGES, 2, synchroniser flop depth (2..3).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- address  in  2  register select.
- chipselect  in  1  slave select.
- read_n  in  1  active-low read strobe.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- in_port  in  WIDTH  external asynchronous inputs.
- readdata  out  32  registered read data.
- irq  out  1  level interrupt, active high.

Behaviour:
- Reset: reset_n is asynchronous, active-low; clock is clk. All flops clear on reset: sync chain, prev, edgecapture, irqmask, readdata, warm-up counter. After reset, readdata=0 and irq=0.
- Sync: in_port passes through SYNC_STAGES flops to give sync_q; prev holds sync_q delayed one cycle.
- Edge detect: rise = sync_q & ~prev; fall = ~sync_q & prev; sel chosen by EDGE_TYPE.
- Warm-up: a counter runs SYNC_STAGES+1 cycles after reset release. While it runs, sel is forced to 0, so no false edges are captured from inputs already high at reset. The counter saturates and stays done until the next reset.
- Latency: an in_port change is visible in sync_q after SYNC_STAGES edges of clk. The matching edgecapture bit sets on the next edge (SYNC_STAGES+1 total). irq follows in the same cycle.
- Register map (only valid when chipselect=1):
  - addr 0 DATA: read-only, returns zero-extended sync_q; writes ignored.
  - addr 1 reserved: reads 0; writes ignored.
  - addr 2 IRQMASK: read/write, WIDTH bits; writes load writedata[WIDTH-1:0].
  - addr 3 EDGECAPTURE: read returns capture bits; write clears each bit where writedata=1 (W1C).
- Capture update each cycle: edgecapture <= (edgecapture & ~clr) | sel.
  - clr = writedata[WIDTH-1:0] when a write hits addr 3, else 0.
  - Simultaneous new edge and clear on the same bit: the edge wins and the bit stays 1.
- Reads: when chipselect & ~read_n, readdata loads the mux output on the next clk edge (read latency 1). Otherwise readdata holds its value.
- A read of EDGECAPTURE returns the value before any same-cycle update. Reads have no side effects.
- Read and write asserted together: both take effect; the read returns the pre-write value.
- irq = |(edgecapture & irqmask), combinational from registers; it is never itself registered.
- Mid-operation reset: state is lost immediately, irq drops, and warm-up restarts.

Decomposition:
- Shared package pio_pkg holds:
  - address constants ADDR_DATA=0, ADDR_RSVD=1, ADDR_IRQMASK=2, ADDR_EDGECAP=3;
  - edge-mode constants EDGE_RISE=0, EDGE_FALL=1, EDGE_ANY=2.
- One natural sub-module, pio_sync_edge: parameterised synchroniser, prev register, warm-up counter and edge select. It outputs sync_q and sel.
- The top-level block keeps the register file, capture logic, read mux and irq.

Test Plan:
- Reset with in_port=32'hFFFF_FFFF, then release, EDGE_TYPE=0 -> DATA reads FFFF_FFFF after SYNC_STAGES+1 cycles; EDGECAPTURE reads 0; irq=0.
- in_port bit 5 goes 0->1, IRQMASK=32'h20 -> EDGECAPTURE=32'h20 exactly SYNC_STAGES+1 cycles later; irq=1 in the same cycle.
- Write 32'h20 to addr 3 -> EDGECAPTURE=0 and irq=0 next cycle. Writing 32'h0 leaves the value unchanged.
- New rising edge on bit 5 arrives in the same cycle as a W1C of 32'h20 -> EDGECAPTURE remains 32'h20; irq stays 1.
- EDGE_TYPE=2, toggle bit 0 high then low with a clear in between -> each transition sets bit 0. IRQMASK=0 keeps irq=0 throughout.
- Assert reset_n low mid-capture with EDGECAPTURE=32'h21 and IRQMASK=32'hFF -> irq drops asynchronously. All registers read 0 after release.
